bsram_copy_engine: RTL and testbench

BSRAM_COPY_ENGINE -- requirements
Module: bsram_copy_engine

---
 rtl/bsram_copy_engine.sv | 162 ++++++++++++++++
 tb/tb_bsram_copy_engine.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/bsram_copy_engine.sv
// bsram_copy_engine
//   Copies a block of words inside a BSRAM: reads src+i, writes dst+i, one
//   word per cycle, ascending. Reads are valid in the same cycle, so each
//   word is registered and written on the following cycle. The memory's
//   write-forwarding makes overlapping forward copies replicate data.
//
//   Optional feature macro: BSRAM_COPY_FILL_EN
//     Adds fillMode/fillData. In fill mode no reads are issued and fillData
//     is written to dst..dst+length-1.
//
// Ports
//   clock, reset                     clock; async active-low reset
//   start                            transfer request, sampled in IDLE only
//   srcAddress, dstAddress, length   transfer parameters, captured on start
//   busy, done                       status (busy: COPY+DONE, done: 1-cycle)
//   readEnable/readAddress/readData  BSRAM read port
//   writeEnable/writeAddress/writeData BSRAM write port
//
// State  | meaning
// IDLE   | waiting for start
// COPY   | issuing reads and/or writes
// DONE   | single-cycle completion pulse
module bsram_copy_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] srcAddress,
  input  logic [ADDR_WIDTH-1:0] dstAddress,
  input  logic [ADDR_WIDTH:0]   length,
`ifdef BSRAM_COPY_FILL_EN
  input  logic                  fillMode,
  input  logic [DATA_WIDTH-1:0] fillData,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  readEnable,
  output logic [ADDR_WIDTH-1:0] readAddress,
  input  logic [DATA_WIDTH-1:0] readData,
  output logic                  writeEnable,
  output logic [ADDR_WIDTH-1:0] writeAddress,
  output logic [DATA_WIDTH-1:0] writeData
);

  typedef enum logic [1:0] {IDLE, COPY, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;

  state_t                state;
  logic [ADDR_WIDTH-1:0] src_ptr;   // next address to read
  logic [ADDR_WIDTH-1:0] dst_ptr;   // next address to write
  logic [ADDR_WIDTH:0]   left;      // down-counter: operations still to issue
`ifdef BSRAM_COPY_FILL_EN
  logic                  fill_q;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      src_ptr      <= '0;
      dst_ptr      <= '0;
      left         <= '0;
`ifdef BSRAM_COPY_FILL_EN
      fill_q       <= 1'b0;
`endif
      busy         <= 1'b0;
      done         <= 1'b0;
      readEnable   <= 1'b0;
      readAddress  <= '0;
      writeEnable  <= 1'b0;
      writeAddress <= '0;
      writeData    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            busy    <= 1'b1;
            src_ptr <= srcAddress + ADDR_ONE;
            dst_ptr <= dstAddress;
            left    <= length - LEN_ONE;
`ifdef BSRAM_COPY_FILL_EN
            fill_q  <= fillMode;
`endif
            if (length == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= COPY;
`ifdef BSRAM_COPY_FILL_EN
              if (fillMode) begin
                // writeData doubles as the captured fill word
                writeEnable  <= 1'b1;
                writeAddress <= dstAddress;
                writeData    <= fillData;
                dst_ptr      <= dstAddress + ADDR_ONE;
              end else
`endif
              begin
                readEnable  <= 1'b1;
                readAddress <= srcAddress;
              end
            end
          end
        end

        COPY: begin
`ifdef BSRAM_COPY_FILL_EN
          if (fill_q) begin
            if (left != '0) begin
              writeAddress <= dst_ptr;
              dst_ptr      <= dst_ptr + ADDR_ONE;
              left         <= left - LEN_ONE;
            end else begin
              state        <= DONE;
              done         <= 1'b1;
              writeEnable  <= 1'b0;
              writeAddress <= '0;
              writeData    <= '0;
            end
          end else
`endif
          if (readEnable) begin
            // word read this cycle is written next cycle
            writeEnable  <= 1'b1;
            writeAddress <= dst_ptr;
            writeData    <= readData;
            dst_ptr      <= dst_ptr + ADDR_ONE;
            if (left != '0) begin
              readAddress <= src_ptr;
              src_ptr     <= src_ptr + ADDR_ONE;
              left        <= left - LEN_ONE;
            end else begin
              readEnable  <= 1'b0;
              readAddress <= '0;
            end
          end else begin
            // final write cycle (no read in flight)
            state        <= DONE;
            done         <= 1'b1;
            writeEnable  <= 1'b0;
            writeAddress <= '0;
            writeData    <= '0;
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bsram_copy_engine.sv
// Testbench for bsram_copy_engine: BSRAM model with write-forwarding,
// table of transfers checked cycle by cycle, plus a reset-abort sequence.
module tb_bsram_copy_engine;

  localparam int DW = 32;
  localparam int AW = 8;
`ifdef BSRAM_COPY_FILL_EN
  localparam int NV = 7;
`else
  localparam int NV = 6;
`endif

  logic          clock, reset, start;
  logic [AW-1:0] srcAddress, dstAddress;
  logic [AW:0]   length;
`ifdef BSRAM_COPY_FILL_EN
  logic          fillMode;
  logic [DW-1:0] fillData;
`endif
  logic          busy, done, readEnable, writeEnable;
  logic [AW-1:0] readAddress, writeAddress;
  logic [DW-1:0] readData, writeData;

  bsram_copy_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .start(start),
    .srcAddress(srcAddress), .dstAddress(dstAddress), .length(length),
`ifdef BSRAM_COPY_FILL_EN
    .fillMode(fillMode), .fillData(fillData),
`endif
    .busy(busy), .done(done),
    .readEnable(readEnable), .readAddress(readAddress), .readData(readData),
    .writeEnable(writeEnable), .writeAddress(writeAddress), .writeData(writeData)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // BSRAM model: one process owns the array (bulk preload or port write)
  logic [DW-1:0] mem [256];
  logic          tb_load;
  always @(posedge clock) begin
    if (tb_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h5A00_0000 + i * 32'h0001_0203;
    end else if (writeEnable) begin
      mem[writeAddress] <= writeData;
    end
  end
  assign readData = (writeEnable && writeAddress == readAddress) ? writeData : mem[readAddress];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  logic [DW-1:0] ref_mem  [256];
  logic [DW-1:0] exp_word [256];

  typedef struct {
    logic [7:0]  s;
    logic [7:0]  d;
    logic [8:0]  len;
    bit          fill;
    logic [31:0] fd;
    bit          poke;      // pulse start again during COPY and DONE
    int          done_k;    // expected cycle of done, counted from start
  } vec_t;

  vec_t vecs [NV];

  task automatic run_xfer(input vec_t v);
    int rd_lo, rd_hi, wr_lo, wr_hi, bad;
    logic          e_re, e_we;
    logic [7:0]    e_ra, e_wa;
    logic [31:0]   e_wd;
    // reference: sequential ascending copy on a snapshot of memory
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    for (int i = 0; i < int'(v.len); i++) begin
      exp_word[8'(i)] = v.fill ? v.fd : ref_mem[8'(v.s + 8'(i))];
      ref_mem[8'(v.d + 8'(i))] = exp_word[8'(i)];
    end
    if (v.fill) begin
      rd_lo = 1; rd_hi = 0; wr_lo = 1; wr_hi = int'(v.len);
    end else begin
      rd_lo = 1; rd_hi = int'(v.len); wr_lo = 2; wr_hi = int'(v.len) + 1;
    end
    if (v.len == 0) wr_hi = wr_lo - 1;

    @(negedge clock);
    start = 1'b1; srcAddress = v.s; dstAddress = v.d; length = v.len;
`ifdef BSRAM_COPY_FILL_EN
    fillMode = v.fill; fillData = v.fd;
`endif
    @(negedge clock);
    start = 1'b0; srcAddress = ~v.s; dstAddress = ~v.d; length = 9'd7;
`ifdef BSRAM_COPY_FILL_EN
    fillMode = ~v.fill; fillData = ~v.fd;
`endif
    for (int k = 1; k <= v.done_k + 1; k++) begin
      e_re = (k >= rd_lo && k <= rd_hi);
      e_ra = e_re ? 8'(v.s + 8'(k - rd_lo)) : 8'h00;
      e_we = (k >= wr_lo && k <= wr_hi);
      e_wa = e_we ? 8'(v.d + 8'(k - wr_lo)) : 8'h00;
      e_wd = 32'h0;
      if (e_we) e_wd = exp_word[8'(k - wr_lo)];
      chk("ctl", {44'h0, busy, done, readEnable, readAddress, writeEnable, writeAddress},
                 {44'h0, 1'(k <= v.done_k), 1'(k == v.done_k), e_re, e_ra, e_we, e_wa});
      chk("wdata", {32'h0, writeData}, {32'h0, e_wd});
      if (v.poke && (k == 2 || k == v.done_k)) begin
        start = 1'b1; srcAddress = 8'h33; length = 9'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
    end
    start = 1'b0;
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem", 64'(bad), 64'd0);
  endtask

  initial begin
    // hand-computed done cycle: copy len+2, fill len+1, zero length 1
    vecs[0] = '{s: 8'h10, d: 8'h80, len: 9'd4,   fill: 1'b0, fd: 32'h0, poke: 1'b1, done_k: 6};
    vecs[1] = '{s: 8'h30, d: 8'h90, len: 9'd0,   fill: 1'b0, fd: 32'h0, poke: 1'b0, done_k: 1};
    vecs[2] = '{s: 8'hFE, d: 8'h02, len: 9'd4,   fill: 1'b0, fd: 32'h0, poke: 1'b0, done_k: 6};
    vecs[3] = '{s: 8'h20, d: 8'h21, len: 9'd3,   fill: 1'b0, fd: 32'h0, poke: 1'b0, done_k: 5};
    vecs[4] = '{s: 8'h05, d: 8'h06, len: 9'd1,   fill: 1'b0, fd: 32'h0, poke: 1'b1, done_k: 3};
    vecs[5] = '{s: 8'h00, d: 8'h80, len: 9'd256, fill: 1'b0, fd: 32'h0, poke: 1'b0, done_k: 258};
`ifdef BSRAM_COPY_FILL_EN
    vecs[6] = '{s: 8'h10, d: 8'h40, len: 9'd3,   fill: 1'b1, fd: 32'hDEADBEEF, poke: 1'b0, done_k: 4};
    fillMode = 1'b0; fillData = '0;
`endif
    reset = 1'b0; start = 1'b0; tb_load = 1'b1;
    srcAddress = '0; dstAddress = '0; length = '0;
    @(negedge clock);
    tb_load = 1'b0;
    @(negedge clock);
    chk("reset_outs", {busy, done, readEnable, readAddress, writeEnable, writeAddress, writeData}, 64'h0);
    reset = 1'b1;
    @(negedge clock);
    chk("idle_outs", {busy, done, readEnable, readAddress, writeEnable, writeAddress, writeData}, 64'h0);

    for (int n = 0; n < NV; n++) run_xfer(vecs[n]);

    // reset in the second COPY cycle of a len=8 copy
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    @(negedge clock);
    start = 1'b1; srcAddress = 8'h50; dstAddress = 8'hA0; length = 9'd8;
`ifdef BSRAM_COPY_FILL_EN
    fillMode = 1'b0;
`endif
    @(negedge clock);
    start = 1'b0;
    chk("rst_pre_busy", {63'h0, busy}, 64'h1);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_outs", {busy, done, readEnable, readAddress, writeEnable, writeAddress, writeData}, 64'h0);
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("post_rst_idle", {60'h0, busy, done, readEnable, writeEnable}, 64'h0);
      @(negedge clock);
    end
    begin
      int bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
      chk("rst_mem", 64'(bad), 64'd0);
    end
    run_xfer('{s: 8'h50, d: 8'hA0, len: 9'd8, fill: 1'b0, fd: 32'h0, poke: 1'b0, done_k: 10});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
